// File: rtl/traffic_phase_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_controller_if
// Description : Sensor inputs and phase outputs of the intersection controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_phase_controller_if;
    logic       ew_str_sensor;
    logic       ew_left_sensor;
    logic       ns_sensor;
    logic [3:0] light_code;
    logic [2:0] served;

    modport master (
        output ew_str_sensor,
        output ew_left_sensor,
        output ns_sensor,
        input  light_code,
        input  served
    );

    modport slave (
        input  ew_str_sensor,
        input  ew_left_sensor,
        input  ns_sensor,
        output light_code,
        output served
    );
endinterface
`default_nettype wire

// File: rtl/traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_controller
// Description : Round-robin light-phase sequencer with min/max green, yellow
//               and all-red clearance timing.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_controller #(
    parameter int GREEN_MIN  = 5,
    parameter int GREEN_MAX  = 10,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    traffic_phase_controller_if.slave  bus
);

    // Counter must hold the largest terminal count of any timed phase.
    localparam int c_MAX_A   = (GREEN_MAX > YELLOW_CYC) ? GREEN_MAX : YELLOW_CYC;
    localparam int c_MAX_B   = (c_MAX_A > ALLRED_CYC) ? c_MAX_A : ALLRED_CYC;
    localparam int c_CNT_W   = (c_MAX_B < 1) ? 1 : $clog2(c_MAX_B + 1);

    localparam logic [c_CNT_W-1:0] c_GMIN_M1 = c_CNT_W'(GREEN_MIN - 1);
    localparam logic [c_CNT_W-1:0] c_GMAX_M1 = c_CNT_W'(GREEN_MAX - 1);
    localparam logic [c_CNT_W-1:0] c_YEL_M1  = c_CNT_W'(YELLOW_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_ARED_M1 = c_CNT_W'(ALLRED_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT = '1;

    localparam logic [2:0] c_APP_EWS = 3'b001;
    localparam logic [2:0] c_APP_EWL = 3'b010;
    localparam logic [2:0] c_APP_NS  = 3'b100;

    // Encoding doubles as the light decoder code.
    typedef enum logic [2:0] {
        ST_ALL_RED = 3'd0,
        ST_EWS_G   = 3'd1,
        ST_EWS_Y   = 3'd2,
        ST_EWL_G   = 3'd3,
        ST_EWL_Y   = 3'd4,
        ST_NS_G    = 3'd5,
        ST_NS_Y    = 3'd6
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_last;
    logic [3:0]           r_light_code;
    logic [2:0]           r_served;

    logic [2:0]           w_req;
    logic [2:0]           w_grant;
    logic                 w_own;
    logic                 w_other;
    logic                 w_green_done;
    logic                 w_yel_done;
    logic                 w_allred_ok;
    state_t               w_next;

    function automatic logic [2:0] served_of(input state_t s);
        logic [2:0] v;
        v = 3'b000;
        case (s)
            ST_EWS_G, ST_EWS_Y: v = c_APP_EWS;
            ST_EWL_G, ST_EWL_Y: v = c_APP_EWL;
            ST_NS_G,  ST_NS_Y:  v = c_APP_NS;
            default:            v = 3'b000;
        endcase
        return v;
    endfunction

    assign w_req = {bus.ns_sensor, bus.ew_left_sensor, bus.ew_str_sensor};

    // Search starts just after the last grant; the last grantee is tried last.
    always_comb begin
        w_grant = 3'b000;
        case (r_last)
            c_APP_EWS: begin
                if      (w_req[1]) w_grant = c_APP_EWL;
                else if (w_req[2]) w_grant = c_APP_NS;
                else if (w_req[0]) w_grant = c_APP_EWS;
            end
            c_APP_EWL: begin
                if      (w_req[2]) w_grant = c_APP_NS;
                else if (w_req[0]) w_grant = c_APP_EWS;
                else if (w_req[1]) w_grant = c_APP_EWL;
            end
            default: begin
                if      (w_req[0]) w_grant = c_APP_EWS;
                else if (w_req[1]) w_grant = c_APP_EWL;
                else if (w_req[2]) w_grant = c_APP_NS;
            end
        endcase
    end

    always_comb begin
        w_own   = 1'b0;
        w_other = 1'b0;
        case (r_state)
            ST_EWS_G: begin w_own = w_req[0]; w_other = w_req[1] | w_req[2]; end
            ST_EWL_G: begin w_own = w_req[1]; w_other = w_req[0] | w_req[2]; end
            ST_NS_G:  begin w_own = w_req[2]; w_other = w_req[0] | w_req[1]; end
            default:  begin w_own = 1'b0;     w_other = 1'b0;                end
        endcase
    end

    assign w_green_done = (r_cnt >= c_GMIN_M1) &&
                          (!w_own || ((r_cnt >= c_GMAX_M1) && w_other));
    assign w_yel_done   = (r_cnt == c_YEL_M1);
    assign w_allred_ok  = (r_cnt >= c_ARED_M1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ALL_RED: begin
                if (w_allred_ok && (w_grant != 3'b000)) begin
                    if      (w_grant[0]) w_next = ST_EWS_G;
                    else if (w_grant[1]) w_next = ST_EWL_G;
                    else                 w_next = ST_NS_G;
                end
            end
            ST_EWS_G: if (w_green_done) w_next = ST_EWS_Y;
            ST_EWL_G: if (w_green_done) w_next = ST_EWL_Y;
            ST_NS_G:  if (w_green_done) w_next = ST_NS_Y;
            ST_EWS_Y, ST_EWL_Y, ST_NS_Y: if (w_yel_done) w_next = ST_ALL_RED;
            default:  w_next = ST_ALL_RED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_ALL_RED;
            r_cnt        <= '0;
            r_last       <= c_APP_NS;
            r_light_code <= 4'd0;
            r_served     <= 3'b000;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_SAT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == ST_ALL_RED) && (w_next != ST_ALL_RED)) begin
                r_last <= w_grant;
            end
            // Outputs track the state being entered, so they stay registered.
            r_light_code <= {1'b0, w_next};
            r_served     <= served_of(w_next);
        end
    end

    assign bus.light_code = r_light_code;
    assign bus.served     = r_served;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_controller
// Description : Scoreboard bench for traffic_phase_controller against a
//               phase-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_controller;

    localparam int GREEN_MIN  = 5;
    localparam int GREEN_MAX  = 10;
    localparam int YELLOW_CYC = 2;
    localparam int ALLRED_CYC = 1;

    typedef struct {
        logic [3:0] code;
        logic [2:0] srv;
        int         cyc;
    } exp_t;

    logic clk;
    logic reset;
    traffic_phase_controller_if bus();

    traffic_phase_controller #(
        .GREEN_MIN  (GREEN_MIN),
        .GREEN_MAX  (GREEN_MAX),
        .YELLOW_CYC (YELLOW_CYC),
        .ALLRED_CYC (ALLRED_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model: approach index (-1 none), colour 0=red 1=green 2=yellow,
    // unbounded time spent in the current phase, index of last grantee.
    int m_app, m_col, m_el, m_last;

    task automatic model_step(input bit rst, input bit [2:0] req);
        int  cand;
        bit  found;
        bit  others;
        if (rst) begin
            m_app = -1; m_col = 0; m_el = 0; m_last = 2;
            return;
        end
        case (m_col)
            0: begin
                found = 0;
                cand  = 0;
                if (m_el >= ALLRED_CYC - 1) begin
                    for (int k = 1; k <= 3; k++) begin
                        if (!found && req[(m_last + k) % 3]) begin
                            found = 1;
                            cand  = (m_last + k) % 3;
                        end
                    end
                end
                if (found) begin
                    m_col = 1; m_app = cand; m_last = cand; m_el = 0;
                end else begin
                    m_el++;
                end
            end
            1: begin
                others = 0;
                for (int k = 0; k < 3; k++)
                    if (k != m_app && req[k]) others = 1;
                if (m_el >= GREEN_MIN - 1 &&
                    (!req[m_app] || (m_el >= GREEN_MAX - 1 && others))) begin
                    m_col = 2; m_el = 0;
                end else begin
                    m_el++;
                end
            end
            default: begin
                if (m_el == YELLOW_CYC - 1) begin
                    m_col = 0; m_app = -1; m_el = 0;
                end else begin
                    m_el++;
                end
            end
        endcase
    endtask

    function automatic int model_code();
        if (m_col == 0) return 0;
        return (m_col == 1) ? 1 + 2 * m_app : 2 + 2 * m_app;
    endfunction

    task automatic drive_cycle(input bit rst, input bit [2:0] req);
        exp_t e;
        @(negedge clk);
        reset              = rst;
        bus.ew_str_sensor  = req[0];
        bus.ew_left_sensor = req[1];
        bus.ns_sensor      = req[2];
        model_step(rst, req);
        e.code = 4'(model_code());
        e.srv  = (m_col == 0) ? 3'b000 : 3'(1 << m_app);
        e.cyc  = cyc;
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic run(input bit [2:0] req, input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, req);
    endtask

    // Monitor: the DUT presents a phase every cycle; compare after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.light_code === e.code) n_pass++;
                else $display("FAIL light_code cyc %0d: got %0d expected %0d",
                              e.cyc, bus.light_code, e.code);
                n_checks++;
                if (bus.served === e.srv) n_pass++;
                else $display("FAIL served cyc %0d: got %b expected %b",
                              e.cyc, bus.served, e.srv);
                n_checks++;
                if (bus.light_code <= 4'd6) n_pass++;
                else $display("FAIL code_range cyc %0d: got %0d expected <= 6",
                              e.cyc, bus.light_code);
            end
        end
    end

    initial begin
        int bound;
        bit [2:0] r;
        int hold;
        reset              = 1'b1;
        bus.ew_str_sensor  = 1'b0;
        bus.ew_left_sensor = 1'b0;
        bus.ns_sensor      = 1'b0;

        drive_cycle(1'b1, 3'b000);
        drive_cycle(1'b1, 3'b000);
        run(3'b000, 50);

        drive_cycle(1'b1, 3'b000);
        run(3'b001, 30);

        drive_cycle(1'b1, 3'b000);
        run(3'b001, 1);
        run(3'b000, 20);

        drive_cycle(1'b1, 3'b000);
        run(3'b101, 60);

        drive_cycle(1'b1, 3'b000);
        run(3'b111, 80);

        // Reset in the middle of the EW-left green restores pointer priority.
        drive_cycle(1'b1, 3'b000);
        bound = 0;
        while (model_code() != 3 && bound < 100) begin
            drive_cycle(1'b0, 3'b111);
            bound++;
        end
        n_checks++;
        if (model_code() == 3) n_pass++;
        else $display("FAIL reach_ewl_green: got code %0d expected 3", model_code());
        run(3'b111, 2);
        drive_cycle(1'b1, 3'b111);
        run(3'b111, 20);

        drive_cycle(1'b1, 3'b000);
        for (int i = 0; i < 300; i++) begin
            r    = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 15);
            for (int j = 0; j < hold; j++)
                drive_cycle(($urandom_range(0, 199) == 0), r);
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
